// File: rtl/router_ctrl.sv
// Control block for the 1x3 packet router: header decode, FIFO write steering,
// upstream backpressure, parity/length check and per-output stall soft reset.
module router_ctrl #(
    parameter int unsigned SOFT_RST_CYCLES = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] data_in,
    input  logic       pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [7:0] fifo_din,
    output logic [1:0] dest,
    output logic       err,
    output logic [2:0] soft_reset
);

    localparam int unsigned CNT_W = $clog2(SOFT_RST_CYCLES + 1);
    localparam int unsigned LEN_W = 6;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FULL_WAIT,
        LOAD_AFTER_FULL,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       header_q, header_d;
    logic [7:0]       parity_q, parity_d;
    logic [7:0]       rx_parity_q, rx_parity_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [1:0]       dest_q, dest_d;
    logic             err_q, err_d;

    logic [2:0][CNT_W-1:0] stall_cnt_q;
    logic [2:0]            sr_fire_c;
    logic [2:0]            soft_reset_q;
    logic [2:0]            dest_oh_c;
    logic                  abort_c;

    // A stall counter fires on the cycle it would reach SOFT_RST_CYCLES
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sr_fire_c[i] = !fifo_empty[i] && !read_enb[i] &&
                           (stall_cnt_q[i] == CNT_W'(SOFT_RST_CYCLES - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_cnt_q  <= '0;
            soft_reset_q <= '0;
        end else begin
            soft_reset_q <= sr_fire_c;
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i] || sr_fire_c[i])
                    stall_cnt_q[i] <= '0;
                else
                    stall_cnt_q[i] <= stall_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign dest_oh_c = 3'b001 << dest_q;
    assign abort_c   = sr_fire_c[dest_q] && (state_q != DECODE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= DECODE;
            header_q    <= '0;
            parity_q    <= '0;
            rx_parity_q <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            count_q     <= '0;
            dest_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            parity_q    <= parity_d;
            rx_parity_q <= rx_parity_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            count_q     <= count_d;
            dest_q      <= dest_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        parity_d    = parity_q;
        rx_parity_d = rx_parity_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        count_d     = count_q;
        dest_d      = dest_q;
        err_d       = err_q;
        busy        = 1'b0;
        write_enb   = 3'b000;
        fifo_din    = 8'h00;

        case (state_q)
            DECODE: begin
                if (pkt_valid && (data_in[1:0] != 2'd3)) begin
                    header_d = data_in;
                    dest_d   = data_in[1:0];
                    parity_d = data_in;
                    count_d  = '0;
                    err_d    = 1'b0;
                    state_d  = fifo_empty[data_in[1:0]] ? LOAD_FIRST : WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (fifo_empty[dest_q])
                    state_d = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy      = 1'b1;
                write_enb = dest_oh_c;
                fifo_din  = header_q;
                state_d   = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (!fifo_full[dest_q]) begin
                    write_enb = dest_oh_c;
                    fifo_din  = data_in;
                    if (pkt_valid) begin
                        parity_d = parity_q ^ data_in;
                        count_d  = (&count_q) ? count_q : count_q + LEN_W'(1);
                    end else begin
                        rx_parity_d = data_in;
                        state_d     = CHECK;
                    end
                end else begin
                    // Byte is consumed into the hold register and replayed later
                    hold_d     = data_in;
                    hold_vld_d = pkt_valid;
                    state_d    = FULL_WAIT;
                end
            end
            FULL_WAIT: begin
                busy = 1'b1;
                if (!fifo_full[dest_q])
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                busy      = 1'b1;
                write_enb = dest_oh_c;
                fifo_din  = hold_q;
                if (hold_vld_q) begin
                    parity_d = parity_q ^ hold_q;
                    count_d  = (&count_q) ? count_q : count_q + LEN_W'(1);
                    state_d  = LOAD_DATA;
                end else begin
                    rx_parity_d = hold_q;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                busy    = 1'b1;
                err_d   = (parity_q != rx_parity_q) || (count_q != header_q[7:2]);
                state_d = DECODE;
            end
            default: state_d = DECODE;
        endcase

        // Flushing the active output abandons the packet in flight
        if (abort_c) begin
            state_d     = DECODE;
            write_enb   = 3'b000;
            fifo_din    = 8'h00;
            hold_d      = '0;
            hold_vld_d  = 1'b0;
            parity_d    = parity_q;
            rx_parity_d = rx_parity_q;
            count_d     = count_q;
            err_d       = err_q;
        end
    end

    assign dest       = dest_q;
    assign err        = err_q;
    assign soft_reset = soft_reset_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed self-checking bench for router_ctrl: normal packets, parity/length
// errors, dropped dest, full backpressure, stall soft reset and mid-packet reset.
module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic [2:0] write_enb;
    logic [7:0] fifo_din;
    logic [1:0] dest;
    logic       err;
    logic [2:0] soft_reset;

    int n_checks = 0;
    int n_errors = 0;

    router_ctrl #(.SOFT_RST_CYCLES(30)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .data_in    (data_in),
        .pkt_valid  (pkt_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .write_enb  (write_enb),
        .fifo_din   (fifo_din),
        .dest       (dest),
        .err        (err),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one source byte, check the combinational outputs of this cycle, advance
    task automatic cc(input string tag, input logic [7:0] d, input logic v,
                      input logic b, input logic [2:0] we, input logic [7:0] din);
        data_in   = d;
        pkt_valid = v;
        #1;
        check({tag, "_busy"}, 8'(busy), 8'(b));
        check({tag, "_we"},   8'(write_enb), 8'(we));
        check({tag, "_din"},  fifo_din, din);
        step();
    endtask

    initial begin
        resetn     = 1'b0;
        data_in    = 8'h00;
        pkt_valid  = 1'b0;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        step();
        step();
        #1;
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_we",   8'(write_enb), 8'h00);
        check("rst_din",  fifo_din, 8'h00);
        check("rst_dest", 8'(dest), 8'h00);
        check("rst_err",  8'(err), 8'h00);
        check("rst_sr",   8'(soft_reset), 8'h00);
        resetn = 1'b1;

        // Good packet to FIFO1
        cc("p1_hdr", 8'h0D, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("p1_lf",  8'h01, 1'b1, 1'b1, 3'b010, 8'h0D);
        cc("p1_d1",  8'h01, 1'b1, 1'b0, 3'b010, 8'h01);
        cc("p1_d2",  8'h02, 1'b1, 1'b0, 3'b010, 8'h02);
        cc("p1_d3",  8'h03, 1'b1, 1'b0, 3'b010, 8'h03);
        cc("p1_par", 8'h0D, 1'b0, 1'b0, 3'b010, 8'h0D);
        cc("p1_chk", 8'h00, 1'b0, 1'b1, 3'b000, 8'h00);
        check("p1_err",  8'(err), 8'h00);
        check("p1_dest", 8'(dest), 8'h01);

        // Same packet, wrong parity byte
        cc("p2_hdr", 8'h0D, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("p2_lf",  8'h01, 1'b1, 1'b1, 3'b010, 8'h0D);
        cc("p2_d1",  8'h01, 1'b1, 1'b0, 3'b010, 8'h01);
        cc("p2_d2",  8'h02, 1'b1, 1'b0, 3'b010, 8'h02);
        cc("p2_d3",  8'h03, 1'b1, 1'b0, 3'b010, 8'h03);
        cc("p2_par", 8'h0C, 1'b0, 1'b0, 3'b010, 8'h0C);
        cc("p2_chk", 8'h00, 1'b0, 1'b1, 3'b000, 8'h00);
        check("p2_err", 8'(err), 8'h01);

        // Dest 3 header is dropped; err survives
        cc("p3_hdr",  8'h0B, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("p3_idle", 8'h00, 1'b0, 1'b0, 3'b000, 8'h00);
        check("p3_err",  8'(err), 8'h01);
        check("p3_dest", 8'(dest), 8'h01);

        // len 2, dest 0, three payload bytes with correct parity -> length error
        cc("p4_hdr", 8'h08, 1'b1, 1'b0, 3'b000, 8'h00);
        check("p4_errclr", 8'(err), 8'h00);
        cc("p4_lf",  8'h11, 1'b1, 1'b1, 3'b001, 8'h08);
        cc("p4_d1",  8'h11, 1'b1, 1'b0, 3'b001, 8'h11);
        cc("p4_d2",  8'h22, 1'b1, 1'b0, 3'b001, 8'h22);
        cc("p4_d3",  8'h33, 1'b1, 1'b0, 3'b001, 8'h33);
        cc("p4_par", 8'h08, 1'b0, 1'b0, 3'b001, 8'h08);
        cc("p4_chk", 8'h00, 1'b0, 1'b1, 3'b000, 8'h00);
        check("p4_err",  8'(err), 8'h01);
        check("p4_dest", 8'(dest), 8'h00);

        // Dest 2, FIFO full on the second payload byte for four cycles
        cc("p5_hdr", 8'h0E, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("p5_lf",  8'hA1, 1'b1, 1'b1, 3'b100, 8'h0E);
        cc("p5_d1",  8'hA1, 1'b1, 1'b0, 3'b100, 8'hA1);
        fifo_full = 3'b100;
        cc("p5_cap", 8'hB2, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("p5_fw1", 8'hC3, 1'b1, 1'b1, 3'b000, 8'h00);
        cc("p5_fw2", 8'hC3, 1'b1, 1'b1, 3'b000, 8'h00);
        cc("p5_fw3", 8'hC3, 1'b1, 1'b1, 3'b000, 8'h00);
        fifo_full = 3'b000;
        cc("p5_fw4", 8'hC3, 1'b1, 1'b1, 3'b000, 8'h00);
        cc("p5_laf", 8'hC3, 1'b1, 1'b1, 3'b100, 8'hB2);
        cc("p5_d3",  8'hC3, 1'b1, 1'b0, 3'b100, 8'hC3);
        cc("p5_par", 8'hDE, 1'b0, 1'b0, 3'b100, 8'hDE);
        cc("p5_chk", 8'h00, 1'b0, 1'b1, 3'b000, 8'h00);
        check("p5_err",  8'(err), 8'h00);
        check("p5_dest", 8'(dest), 8'h02);

        // Stalled reader on output 0: pulse after exactly 30 cycles
        data_in    = 8'h00;
        pkt_valid  = 1'b0;
        fifo_empty = 3'b110;
        for (int k = 1; k <= 29; k++) begin
            step();
            check($sformatf("sr_wait%0d", k), 8'(soft_reset), 8'h00);
        end
        step();
        check("sr_pulse", 8'(soft_reset), 8'h01);
        step();
        check("sr_after", 8'(soft_reset), 8'h00);
        fifo_empty = 3'b111;
        step();

        // A read at cycle 29 restarts the count
        fifo_empty = 3'b110;
        for (int k = 1; k <= 28; k++) step();
        read_enb = 3'b001;
        step();
        check("srr_29", 8'(soft_reset), 8'h00);
        read_enb = 3'b000;
        step();
        check("srr_30", 8'(soft_reset), 8'h00);
        step();
        check("srr_31", 8'(soft_reset), 8'h00);
        fifo_empty = 3'b111;
        step();

        // Soft reset on the active dest aborts a packet parked in FULL_WAIT
        cc("ab_hdr", 8'h0C, 1'b1, 1'b0, 3'b000, 8'h00);
        fifo_empty = 3'b110;
        cc("ab_lf",  8'h01, 1'b1, 1'b1, 3'b001, 8'h0C);
        fifo_full = 3'b001;
        cc("ab_cap", 8'h01, 1'b1, 1'b0, 3'b000, 8'h00);
        data_in = 8'h02;
        for (int k = 3; k <= 29; k++) begin
            #1;
            check($sformatf("ab_fw%0d", k), 8'(busy), 8'h01);
            step();
        end
        check("ab_sr_hold", 8'(soft_reset), 8'h00);
        step();
        pkt_valid = 1'b0;
        #1;
        check("ab_sr",   8'(soft_reset), 8'h01);
        check("ab_busy", 8'(busy), 8'h00);
        check("ab_we",   8'(write_enb), 8'h00);
        check("ab_err",  8'(err), 8'h00);
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        cc("ab_idle", 8'h00, 1'b0, 1'b0, 3'b000, 8'h00);
        check("ab_sr_end", 8'(soft_reset), 8'h00);

        // Reset mid-payload, then a packet that waits for FIFO2 to drain
        cc("r_hdr", 8'h0D, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("r_lf",  8'h01, 1'b1, 1'b1, 3'b010, 8'h0D);
        cc("r_d1",  8'h01, 1'b1, 1'b0, 3'b010, 8'h01);
        data_in = 8'h02;
        resetn  = 1'b0;
        step();
        resetn    = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        #1;
        check("rm_busy", 8'(busy), 8'h00);
        check("rm_we",   8'(write_enb), 8'h00);
        check("rm_din",  fifo_din, 8'h00);
        check("rm_dest", 8'(dest), 8'h00);
        check("rm_err",  8'(err), 8'h00);
        fifo_empty = 3'b011;
        cc("n_hdr", 8'h0E, 1'b1, 1'b0, 3'b000, 8'h00);
        cc("n_we1", 8'h01, 1'b1, 1'b1, 3'b000, 8'h00);
        fifo_empty = 3'b111;
        cc("n_we2", 8'h01, 1'b1, 1'b1, 3'b000, 8'h00);
        cc("n_lf",  8'h01, 1'b1, 1'b1, 3'b100, 8'h0E);
        cc("n_d1",  8'h01, 1'b1, 1'b0, 3'b100, 8'h01);
        cc("n_d2",  8'h02, 1'b1, 1'b0, 3'b100, 8'h02);
        cc("n_d3",  8'h03, 1'b1, 1'b0, 3'b100, 8'h03);
        cc("n_par", 8'h0E, 1'b0, 1'b0, 3'b100, 8'h0E);
        cc("n_chk", 8'h00, 1'b0, 1'b1, 3'b000, 8'h00);
        check("n_err",  8'(err), 8'h00);
        check("n_dest", 8'(dest), 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
